// File: rtl/mips_pkg.sv
// mips_pkg: constants and loader state encoding shared across the MIPS support blocks
package mips_pkg;
  localparam logic [7:0] START_BYTE = 8'hA5;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, RUN, ERROR} state_t;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: shifts bytes MSB-first into a 32-bit word and keeps a running XOR checksum
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        shift,
  input  logic        clear,
  output logic [31:0] word,
  output logic [7:0]  csum,
  output logic [1:0]  idx
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      word <= '0;
      csum <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      csum <= '0;
      idx  <= '0;
    end else if (shift) begin
      word <= {word[23:0], din};
      csum <= csum ^ din;
      idx  <= idx + 2'd1;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream, writes instruction words to memory,
// then releases the core from reset once the checksum matches
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);
  state_t     state;
  logic [7:0] n, cnt, csum;
  logic [1:0] idx;
  logic       xfer;
  assign rx_ready = state != WRITE;
  assign xfer     = rx_valid && rx_ready;
  word_assembler u_asm (
    .clk  (clk),
    .reset(reset),
    .din  (rx_data),
    .shift(xfer && state == DATA),
    .clear(xfer && state == COUNT),
    .word (imem_wdata),
    .csum (csum),
    .idx  (idx)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      n         <= '0;
      cnt       <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: if (xfer && rx_data == START_BYTE) state <= COUNT;
        COUNT: if (xfer) begin
          if (rx_data == 8'd0) begin
            state <= ERROR;
            error <= 1'b1;
          end else begin
            n         <= rx_data;
            cnt       <= '0;
            imem_addr <= '0;
            state     <= DATA;
          end
        end
        DATA: if (xfer && idx == 2'd3) begin
          state   <= WRITE;
          imem_we <= 1'b1;
        end
        WRITE: begin
          imem_addr <= imem_addr + ADDR_WIDTH'(1);
          cnt       <= cnt + 8'd1;
          state     <= (cnt == n - 8'd1) ? CHECK : DATA;
        end
        CHECK: if (xfer) begin
          state     <= (rx_data == csum) ? RUN : ERROR;
          cpu_reset <= rx_data != csum;
          done      <= rx_data == csum;
          error     <= rx_data != csum;
        end
        RUN: if (xfer && rx_data == START_BYTE) begin
          state     <= COUNT;
          cpu_reset <= 1'b1;
          done      <= 1'b0;
        end
        ERROR: if (xfer && rx_data == START_BYTE) begin
          state <= COUNT;
          error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frame sequences checked with immediate assertions
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, imem_we, cpu_reset, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  int          vectors = 0;
  int          miscompares = 0;
  int          nw = 0;
  int          nr = 0;
  int          r0;
  logic [7:0]  wa [16];
  logic [31:0] wd [16];

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset) begin
      if (imem_we && nw < 16) begin
        wa[nw] = imem_addr;
        wd[nw] = imem_wdata;
      end
      if (imem_we) nw++;
      if (!rx_ready) nr++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      vectors++;
      miscompares++;
      $error("FAIL ready_timeout: observed rx_ready=0 for %0d cycles expected 1", k);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_g(input logic [7:0] b, input bit gap);
    if (gap) repeat (2) @(negedge clk);
    send(b);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) send_g(w[8*i +: 8], gap);
  endtask

  task automatic chk_wr(input int i, input logic [7:0] a, input logic [31:0] d);
    chk($sformatf("wr%0d_addr", i), {24'd0, wa[i]}, {24'd0, a});
    chk($sformatf("wr%0d_data", i), wd[i], d);
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 0);
    chk({tag, "_error"}, {31'd0, error}, 0);
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 1);
    chk({tag, "_error"}, {31'd0, error}, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, rx_ready}, 1);
    chk("rst_we", {31'd0, imem_we}, 0);
    chk("rst_addr", {24'd0, imem_addr}, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_error", {31'd0, error}, 0);
    reset = 1'b1;
    send(8'h3C);
    chk("idle_discard_cpu_reset", {31'd0, cpu_reset}, 1);

    send(8'hA5); send(8'h01); send_word(32'h20020004, 0); send(8'h26);
    chk_run("one_word");
    chk("one_word_nw", nw, 1);
    chk_wr(0, 8'd0, 32'h20020004);
    chk("one_word_addr_hold", {24'd0, imem_addr}, 1);

    send(8'hA5);
    chk("reload_cpu_reset", {31'd0, cpu_reset}, 1);
    chk("reload_done", {31'd0, done}, 0);
    send(8'h02); send_word(32'h00621820, 0); send_word(32'h00433822, 0); send(8'h00);
    chk_err("two_word_badsum");
    chk("two_word_badsum_nw", nw, 3);
    chk_wr(1, 8'd0, 32'h00621820);
    chk_wr(2, 8'd1, 32'h00433822);

    send(8'hA5);
    chk("err_clear_on_count", {31'd0, error}, 0);
    // XOR of 00 62 18 20 00 43 38 22 is 0x03
    send(8'h02); send_word(32'h00621820, 0); send_word(32'h00433822, 0); send(8'h03);
    chk_run("two_word");
    chk("two_word_nw", nw, 5);
    chk_wr(3, 8'd0, 32'h00621820);
    chk_wr(4, 8'd1, 32'h00433822);

    send(8'hA5); send(8'h01); send_word(32'h20020004, 0); send(8'h27);
    chk_err("bad_sum");
    chk("bad_sum_nw", nw, 6);
    send(8'h11);
    chk("err_ignore", {31'd0, error}, 1);
    send(8'hA5); send(8'h01); send_word(32'h20020004, 0); send(8'h26);
    chk_run("recover");
    chk("recover_nw", nw, 7);

    send(8'hA5); send(8'h00);
    chk_err("zero_count");
    chk("zero_count_nw", nw, 7);

    r0 = nr;
    send_g(8'hA5, 1); send_g(8'h02, 1);
    send_word(32'h00621820, 1); send_word(32'h00433822, 1); send_g(8'h03, 1);
    chk_run("gapped");
    chk("gapped_nw", nw, 9);
    chk_wr(7, 8'd0, 32'h00621820);
    chk_wr(8, 8'd1, 32'h00433822);
    chk("gapped_not_ready_cycles", nr - r0, 2);

    send(8'hA5); send(8'h01); send_word(32'hA5A5A5A5, 0); send(8'h00);
    chk_run("a5_payload");
    chk("a5_payload_nw", nw, 10);
    chk_wr(9, 8'd0, 32'hA5A5A5A5);

    send(8'hA5); send(8'h02); send(8'h00); send(8'h62);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, rx_ready}, 1);
    chk("midrst_we", {31'd0, imem_we}, 0);
    chk("midrst_addr", {24'd0, imem_addr}, 0);
    chk("midrst_wdata", imem_wdata, 0);
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 1);
    chk("midrst_done", {31'd0, done}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send(8'h18); send(8'h20);
    repeat (5) @(negedge clk);
    chk("postrst_nw", nw, 10);
    chk("postrst_ready", {31'd0, rx_ready}, 1);
    chk("postrst_cpu_reset", {31'd0, cpu_reset}, 1);
    chk("postrst_error", {31'd0, error}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
